// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetcher: issues sequential word fetches ahead of decode, buffers {pc, inst}
// pairs in an in-order FIFO and flushes/discards in-flight data on a taken branch.

module inst_prefetch_buffer_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             push,
  input logic             pop,
  input logic             rvalid,
  input logic [CNT_W-1:0] fifo_count,
  input logic [CNT_W-1:0] outstanding
);

  // Credit accounting must keep buffered plus in-flight words within the FIFO size
  a_credit: assert property (@(posedge clk_i) disable iff (!rst_i)
    ({1'b0, fifo_count} + {1'b0, outstanding}) <= (CNT_W+1)'(DEPTH));

  // A write into a full FIFO without a simultaneous read would overwrite the head
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push && !pop && (fifo_count == CNT_W'(DEPTH))));

  // The memory never answers a request that was not issued
  a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(rvalid && (outstanding == {CNT_W{1'b0}})));

endmodule

module inst_prefetch_buffer #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] resp_pc_r;
  logic [CNT_W-1:0]  fifo_count_r;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  discard_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
  logic [DATA_W-1:0] inst_mem_r [DEPTH];

  logic [CNT_W:0]    inflight_s;
  logic              credit_ok_s;
  logic              req_s;
  logic              issue_s;
  logic              head_valid_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] target_pc_s;

  logic [ADDR_W-1:0] fetch_pc_nxt_s;
  logic [ADDR_W-1:0] resp_pc_nxt_s;
  logic [CNT_W-1:0]  fifo_count_nxt_s;
  logic [CNT_W-1:0]  outstanding_nxt_s;
  logic [CNT_W-1:0]  discard_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;

  // Requests are gated by reset so the port is quiet while rst_i is low, even without a clock
  assign inflight_s   = {1'b0, fifo_count_r} + {1'b0, outstanding_r};
  assign credit_ok_s  = inflight_s < (CNT_W+1)'(DEPTH);
  assign req_s        = rst_i & start_i & ~redirect_i & credit_ok_s;
  assign issue_s      = req_s & mem_gnt_i;
  assign head_valid_s = fifo_count_r != {CNT_W{1'b0}};
  assign push_s       = mem_rvalid_i & (discard_r == {CNT_W{1'b0}}) & ~redirect_i;
  assign pop_s        = head_valid_s & inst_ready_i & ~redirect_i;
  assign target_pc_s  = redirect_pc_i & ~ADDR_W'(2'b11);

  assign mem_req_o    = req_s;
  assign mem_addr_o   = fetch_pc_r;
  assign inst_valid_o = head_valid_s;
  assign inst_o       = head_valid_s ? inst_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign inst_pc_o    = head_valid_s ? pc_mem_r[rd_ptr_r]   : {ADDR_W{1'b0}};

  // Next-state: fetch/response PCs, credit counters, discard count and FIFO pointers
  always_comb begin
    fetch_pc_nxt_s    = fetch_pc_r;
    resp_pc_nxt_s     = resp_pc_r;
    fifo_count_nxt_s  = fifo_count_r;
    discard_nxt_s     = discard_r;
    rd_ptr_nxt_s      = rd_ptr_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    outstanding_nxt_s = outstanding_r + CNT_W'(issue_s) - CNT_W'(mem_rvalid_i);

    if (redirect_i) begin
      // Everything still in flight after this edge belongs to the abandoned path
      fetch_pc_nxt_s   = target_pc_s;
      resp_pc_nxt_s    = target_pc_s;
      fifo_count_nxt_s = {CNT_W{1'b0}};
      discard_nxt_s    = outstanding_nxt_s;
      rd_ptr_nxt_s     = {PTR_W{1'b0}};
      wr_ptr_nxt_s     = {PTR_W{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_nxt_s = fetch_pc_r + ADDR_W'(3'd4);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end

      if (mem_rvalid_i && (discard_r != {CNT_W{1'b0}})) begin
        discard_nxt_s = discard_r - CNT_W'(1'b1);
      end else begin
        discard_nxt_s = discard_r;
      end

      if (push_s) begin
        resp_pc_nxt_s = resp_pc_r + ADDR_W'(3'd4);
        wr_ptr_nxt_s  = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        resp_pc_nxt_s = resp_pc_r;
        wr_ptr_nxt_s  = wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({push_s, pop_s})
        2'b10:   fifo_count_nxt_s = fifo_count_r + CNT_W'(1'b1);
        2'b01:   fifo_count_nxt_s = fifo_count_r - CNT_W'(1'b1);
        default: fifo_count_nxt_s = fifo_count_r;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      fifo_count_r  <= {CNT_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
      discard_r     <= {CNT_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      resp_pc_r     <= resp_pc_nxt_s;
      fifo_count_r  <= fifo_count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_r[i]   <= {ADDR_W{1'b0}};
        inst_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= resp_pc_r;
      inst_mem_r[wr_ptr_r] <= mem_rdata_i;
    end
  end

  inst_prefetch_buffer_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push        (push_s),
    .pop         (pop_s),
    .rvalid      (mem_rvalid_i),
    .fifo_count  (fifo_count_r),
    .outstanding (outstanding_r)
  );

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer with a latency-configurable memory model and
// a {pc, inst} scoreboard checked on every consumer handshake.

module tb_inst_prefetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  int n_grants = 0;
  int n_pops = 0;
  logic [31:0] exp_issue_pc = 32'h0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];

  inst_prefetch_buffer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: record issued requests, retire them when their response is taken
  always @(posedge clk_i) begin
    if (!rst_i) begin
      pend_q.delete();
    end else begin
      if (mem_rvalid_i && pend_q.size() > 0) void'(pend_q.pop_front());
      if (mem_req_o && mem_gnt_i) pend_q.push_back('{mem_addr_o, cyc + lat});
    end
    cyc <= cyc + 1;
  end

  // Memory model: present the oldest response once its latency has elapsed
  always @(negedge clk_i) begin
    if (rst_i && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_rvalid_i <= 1'b1;
      mem_rdata_i  <= mem_f(pend_q[0].addr);
    end else begin
      mem_rvalid_i <= 1'b0;
      mem_rdata_i  <= 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [31:0] start_pc, input int n);
    logic [31:0] pc;
    pc = start_pc;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, mem_f(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // One cycle: check this cycle's issue and handshake, then move to the next low phase
  task automatic tick();
    logic [63:0] exp_e;
    #1;
    if (mem_req_o && mem_gnt_i) begin
      chk("issue_addr", {32'h0, mem_addr_o}, {32'h0, exp_issue_pc});
      exp_issue_pc = exp_issue_pc + 32'd4;
      n_grants++;
    end
    if (inst_valid_o && inst_ready_i && !redirect_i) begin
      n_pops++;
      if (exp_q.size() == 0) exp_e = 64'hFFFF_FFFF_FFFF_FFFF;
      else exp_e = exp_q.pop_front();
      chk("head", {inst_pc_o, inst_o}, exp_e);
    end
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    start_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    mem_gnt_i = 1'b0;
    inst_ready_i = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    exp_issue_pc = 32'h0;
    n_grants = 0;
    n_pops = 0;
    rst_i = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    #1;
    chk("redirect_no_req", 64'(mem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    exp_q.delete();
    push_expected(pc & 32'hFFFF_FFFC, 32);
    exp_issue_pc = pc & 32'hFFFF_FFFC;
    chk("redirect_flush", 64'(inst_valid_o), 64'd0);
  endtask

  initial begin
    @(negedge clk_i);
    #1;
    // Reset state with fetch enabled: outputs must stay at reset values
    start_i = 1'b1;
    #1;
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_addr", {32'h0, mem_addr_o}, 64'd0);
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", {32'h0, inst_o}, 64'd0);
    chk("rst_pc", {32'h0, inst_pc_o}, 64'd0);

    // 1: streaming with a 1-cycle memory
    do_reset();
    push_expected(32'h0, 32);
    lat = 1; start_i = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    #1;
    chk("t1_c0_valid", 64'(inst_valid_o), 64'd0);
    tick();
    chk("t1_c1_valid", 64'(inst_valid_o), 64'd0);
    tick();
    chk("t1_c2_valid", 64'(inst_valid_o), 64'd1);
    chk("t1_c2_pc", {32'h0, inst_pc_o}, 64'd0);
    repeat (10) tick();
    chk("t1_throughput", 64'(n_pops), 64'd10);

    // 2: consumer stalled, credits bound the prefetch depth
    do_reset();
    push_expected(32'h0, 32);
    lat = 1; start_i = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b0;
    repeat (10) tick();
    chk("t2_grants", 64'(n_grants), 64'd4);
    chk("t2_req_off", 64'(mem_req_o), 64'd0);
    chk("t2_head_pc", {32'h0, inst_pc_o}, 64'd0);
    inst_ready_i = 1'b1;
    for (int i = 0; i < 20 && n_pops < 5; i++) tick();
    chk("t2_drain", 64'(n_pops), 64'd5);

    // 3: redirect with three fetches in flight on a 3-cycle memory
    do_reset();
    push_expected(32'h0, 32);
    lat = 3; start_i = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    repeat (3) tick();
    chk("t3_inflight", 64'(n_grants), 64'd3);
    do_redirect(32'h0000_0103);
    for (int i = 0; i < 40 && n_pops < 4; i++) tick();
    chk("t3_pops", 64'(n_pops), 64'd4);

    // 4: redirect, grant and response in the same cycle
    do_reset();
    push_expected(32'h0, 32);
    lat = 1; start_i = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    tick();
    do_redirect(32'h0000_0200);
    for (int i = 0; i < 20 && n_pops < 3; i++) tick();
    chk("t4_pops", 64'(n_pops), 64'd3);

    // 5: grant withheld, request must hold steady; start low withdraws it
    do_reset();
    push_expected(32'h0, 32);
    lat = 1; start_i = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    repeat (2) tick();
    mem_gnt_i = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_req_hold", 64'(mem_req_o), 64'd1);
      chk("t5_addr_hold", {32'h0, mem_addr_o}, 64'h8);
      tick();
    end
    start_i = 1'b0;
    #1;
    chk("t5_req_withdrawn", 64'(mem_req_o), 64'd0);
    tick();
    start_i = 1'b1;
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 20 && n_pops < 3; i++) tick();
    chk("t5_pops", 64'(n_pops), 64'd3);

    // 6: address wrap at the top of memory, then asynchronous reset mid-burst
    do_reset();
    lat = 1; start_i = 1'b1; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    do_redirect(32'hFFFF_FFFE);
    chk("t6_addr_top", {32'h0, mem_addr_o}, 64'hFFFF_FFFC);
    tick();
    chk("t6_addr_wrap", {32'h0, mem_addr_o}, 64'h0);
    for (int i = 0; i < 20 && n_pops < 3; i++) tick();
    chk("t6_pops", 64'(n_pops), 64'd3);
    chk("t6_busy_valid", 64'(inst_valid_o), 64'd1);
    rst_i = 1'b0;
    #1;
    chk("t6_arst_req", 64'(mem_req_o), 64'd0);
    chk("t6_arst_addr", {32'h0, mem_addr_o}, 64'd0);
    chk("t6_arst_valid", 64'(inst_valid_o), 64'd0);
    chk("t6_arst_inst", {32'h0, inst_o}, 64'd0);
    chk("t6_arst_pc", {32'h0, inst_pc_o}, 64'd0);
    repeat (2) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
